// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// default memory latency and the alignment rule.
package lsu_pkg;

  localparam int unsigned MEM_LATENCY_DEF = 2;
  localparam int CNT_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  // Size 2'b11 has no legal alignment, so it is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      SZ_WORD: is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction with sign/zero extension and
// store merge into a read word. Lane 0 is the most significant byte.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            sign_ext,
  input  logic [1:0]      addr_lo,
  input  logic [0:3][7:0] rdata,
  input  logic [31:0]     wdata,
  output logic [31:0]     load_ext,
  output logic [0:3][7:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = rdata[addr_lo];
    half_v   = addr_lo[1] ? {rdata[2], rdata[3]} : {rdata[0], rdata[1]};
    load_ext = rdata;
    merged   = rdata;
    case (size)
      SZ_BYTE: begin
        load_ext        = {{24{sign_ext & byte_v[7]}}, byte_v};
        merged[addr_lo] = wdata[7:0];
      end
      SZ_HALF: begin
        load_ext                  = {{16{sign_ext & half_v[15]}}, half_v};
        merged[{addr_lo[1], 1'b0}] = wdata[15:8];
        merged[{addr_lo[1], 1'b1}] = wdata[7:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: a 4-state FSM that turns core byte/half/word requests into
// aligned word reads, whole-word writes and read-modify-write sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  output logic            stall,
  output logic            load_valid,
  output logic [31:0]     load_data,
  output logic            misaligned,
  output logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_out,
  output logic [0:3][7:0] mem_data_in,
  output logic            mem_write_en
);

  lsu_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic             signed_q;
  logic             write_q;
  logic [0:3][7:0]  wword_q;   // store data at accept, merged word after the read
  logic             req_mis;
  logic             accept;
  logic [31:0]      load_ext;
  logic [0:3][7:0]  merged;

  assign req_mis     = is_misaligned(req_size, req_addr[1:0]);
  assign accept      = (state == IDLE) && req_valid && !req_mis;
  assign mem_addr    = {addr_q[31:2], 2'b00};
  assign mem_data_in = wword_q;

  lsu_align u_align (
    .size     (size_q),
    .sign_ext (signed_q),
    .addr_lo  (addr_q[1:0]),
    .rdata    (mem_data_out),
    .wdata    (wword_q),
    .load_ext (load_ext),
    .merged   (merged)
  );

  always_comb begin
    state_n      = state;
    stall        = 1'b0;
    load_valid   = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_n = (req_write && req_size == SZ_WORD) ? WRITE : READ;
        end
      end
      READ: begin
        stall = 1'b1;
        if (cnt == '0) state_n = write_q ? WRITE : DONE;
      end
      WRITE: begin
        stall        = 1'b1;
        mem_write_en = 1'b1;
        state_n      = DONE;
      end
      DONE: begin
        load_valid = !write_q;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wword_q    <= '0;
      load_data  <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_n;
      misaligned <= (state == IDLE) && req_valid && req_mis;
      if (accept) begin
        addr_q   <= req_addr;
        size_q   <= req_size;
        signed_q <= req_signed;
        write_q  <= req_write;
        wword_q  <= req_wdata;
        cnt      <= CNT_W'(MEM_LATENCY - 1);
      end
      if (state == READ) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else if (write_q) begin
          wword_q <= merged;
        end else begin
          load_data <= load_ext;
        end
      end
    end
  end

endmodule
